// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions
// and the default exception vector.
package cp0_pkg;

  // CP0 register numbers (rd field, sel=0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status field positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  // Cause field positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RESET       = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

  // Address-error exceptions are the only ones that latch BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 signal bundle. The pipeline is the master, CP0 the slave.
interface cp0_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [31:0]           exc_pc;
  logic                  exc_bd;
  logic [31:0]           exc_badvaddr;
  logic                  eret;
  logic                  mtc0_we;
  logic [4:0]            cp0_addr;
  logic [31:0]           mtc0_wdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic [31:0]           mfc0_rdata;
  logic                  int_pending;
  logic                  flush;
  logic [31:0]           flush_pc;
  logic                  status_exl;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
           mtc0_we, cp0_addr, mtc0_wdata, hw_int,
    input  mfc0_rdata, int_pending, flush, flush_pc, status_exl
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
           mtc0_we, cp0_addr, mtc0_wdata, hw_int,
    output mfc0_rdata, int_pending, flush, flush_pc, status_exl
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the
// sticky timer interrupt TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  assign tick = (phase_q == PHASE_LAST);

  // Next state: a Count write pre-empts the tick and restarts the prescaler;
  // a Compare write clears TI even if the same tick would have set it.
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      phase_d = '0;
    end else begin
      phase_d = tick ? '0 : phase_q + 1'b1;
      if (tick) begin
        count_d = count_q + 32'd1;
        if (count_q + 32'd1 == compare_q) ti_d = 1'b1;
      end
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr, precise exception entry and
// ERET, interrupt masking, mfc0 read mux and pipeline flush/redirect.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          TIMER_EN   = 1,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input logic clk,
  input logic resetn,
  cp0_if.slave cp
);

  logic [5:0]  hw_ext;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        mtc0_take;
  logic [31:0] count, compare;
  logic        ti, ti_eff;
  logic [7:0]  cause_ip;
  logic [31:0] status_word, cause_word;

  // Zero-extend the external lines up to the six Cause.IP hardware bits
  for (genvar gi = 0; gi < 6; gi++) begin : g_hw_ext
    if (gi < NUM_HW_INT) begin : g_used
      assign hw_ext[gi] = cp.hw_int[gi];
    end else begin : g_tied
      assign hw_ext[gi] = 1'b0;
    end
  end

  // An mtc0 is dropped whenever an exception or ERET claims the cycle
  assign mtc0_take = cp.mtc0_we & ~cp.exc_valid & ~cp.eret;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .count_we_i   (mtc0_take && (cp.cp0_addr == CP0_COUNT)),
    .compare_we_i (mtc0_take && (cp.cp0_addr == CP0_COMPARE)),
    .wdata_i      (cp.mtc0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  assign ti_eff      = (TIMER_EN != 0) ? ti : 1'b0;
  assign cause_ip    = {ip_hw_q[5] | ti_eff, ip_hw_q[4:0], ip_sw_q};
  assign status_word = STATUS_RESET | {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_word  = {bd_q, 15'h0, cause_ip, 1'b0, exc_code_q, 2'b00};

  // mfc0 read mux; unimplemented registers read as zero
  always_comb begin
    cp.mfc0_rdata = 32'h0;
    case (cp.cp0_addr)
      CP0_BADVADDR: cp.mfc0_rdata = badvaddr_q;
      CP0_COUNT:    cp.mfc0_rdata = count;
      CP0_COMPARE:  cp.mfc0_rdata = compare;
      CP0_STATUS:   cp.mfc0_rdata = status_word;
      CP0_CAUSE:    cp.mfc0_rdata = cause_word;
      CP0_EPC:      cp.mfc0_rdata = epc_q;
      default:      cp.mfc0_rdata = 32'h0;
    endcase
  end

  // Next state: exception beats ERET beats mtc0; IP sampling always happens
  always_comb begin
    ip_hw_d    = hw_ext;
    ip_sw_d    = ip_sw_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (cp.exc_valid) begin
      // Nested exceptions keep the EPC/BD of the outermost one
      if (!exl_q) begin
        epc_d = cp.exc_bd ? cp.exc_pc - 32'd4 : cp.exc_pc;
        bd_d  = cp.exc_bd;
      end
      exl_d      = 1'b1;
      exc_code_d = cp.exc_code;
      if (is_addr_exc(cp.exc_code)) badvaddr_d = cp.exc_badvaddr;
    end else if (cp.eret) begin
      exl_d = 1'b0;
    end else if (cp.mtc0_we) begin
      case (cp.cp0_addr)
        CP0_STATUS: begin
          im_d  = cp.mtc0_wdata[ST_IM_LO +: 8];
          exl_d = cp.mtc0_wdata[ST_EXL];
          ie_d  = cp.mtc0_wdata[ST_IE];
        end
        CP0_CAUSE: ip_sw_d = cp.mtc0_wdata[CA_IP_LO +: 2];
        CP0_EPC:   epc_d   = cp.mtc0_wdata;
        default:   ;
      endcase
    end
  end

  // Architectural register file
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign cp.int_pending = ie_q & ~exl_q & |(cause_ip & im_q);
  assign cp.flush       = cp.exc_valid | cp.eret;
  assign cp.flush_pc    = cp.exc_valid ? EXC_VECTOR : epc_q;
  assign cp.status_exl  = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized
// traffic, all compared against an architectural model of CP0.
module tb_cp0_unit;

  localparam int          DIV = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  cp0_if #(.NUM_HW_INT(6)) bus();

  cp0_unit #(.NUM_HW_INT(6), .TIMER_EN(1), .COUNT_DIV(DIV), .EXC_VECTOR(VEC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cp     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural model state
  logic [31:0] m_badv, m_count, m_compare, m_epc;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_code;
  logic [1:0]  m_swip;
  logic [5:0]  m_hw;
  int          m_cyc;   // clock edges since Count was last written / reset

  function automatic logic [7:0] exp_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_swip};
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'h0, exp_ip(), 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_int();
    return m_ie & ~m_exl & (|(exp_ip() & m_im));
  endfunction

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0;
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_code = 0; m_swip = 0; m_hw = 0; m_cyc = 0;
  endtask

  // Apply one clock edge of architectural behaviour to the model
  task automatic model_edge();
    logic take;
    logic [31:0] wd;
    take = bus.mtc0_we & ~bus.exc_valid & ~bus.eret;
    wd   = bus.mtc0_wdata;
    if (take && bus.cp0_addr == 5'd9) begin
      m_count = wd;
      m_cyc   = 0;
    end else begin
      if ((m_cyc % DIV) == DIV - 1) begin
        if (m_count + 32'd1 == m_compare) m_ti = 1'b1;
        m_count = m_count + 32'd1;
      end
      m_cyc++;
    end
    if (take && bus.cp0_addr == 5'd11) begin
      m_compare = wd;
      m_ti      = 1'b0;
    end
    m_hw = bus.hw_int;
    if (bus.exc_valid) begin
      if (!m_exl) begin
        m_epc = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        m_bd  = bus.exc_bd;
      end
      m_exl  = 1'b1;
      m_code = bus.exc_code;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) m_badv = bus.exc_badvaddr;
    end else if (bus.eret) begin
      m_exl = 1'b0;
    end else if (take) begin
      if (bus.cp0_addr == 5'd12) begin
        m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
      end else if (bus.cp0_addr == 5'd13) begin
        m_swip = wd[9:8];
      end else if (bus.cp0_addr == 5'd14) begin
        m_epc = wd;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0; bus.exc_bd = 0;
    bus.exc_badvaddr = 0; bus.eret = 0; bus.mtc0_we = 0; bus.cp0_addr = 0;
    bus.mtc0_wdata = 0; bus.hw_int = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we = 1; bus.cp0_addr = a; bus.mtc0_wdata = d;
    step();
    bus.mtc0_we = 0;
    $display("mtc0 r%0d <= %h", a, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.mfc0_rdata;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [4];
    logic [31:0] exps  [4];
    logic [31:0] d;
    addrs = '{5'd12, 5'd13, 5'd14, 5'd8};
    exps  = '{32'h0040_0000, 32'h0, 32'h0, 32'h0};
    idle();
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d);
      vectors++;
      if (d !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_r%0d: got %h want %h", addrs[i], d, exps[i]);
      end
    end
    vectors++;
    if (bus.flush !== 1'b0 || bus.int_pending !== 1'b0 || bus.status_exl !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outs: flush/int/exl got %b%b%b want 000",
               bus.flush, bus.int_pending, bus.status_exl);
    end
    $display("reset checked");
  endtask

  task automatic test_exception();
    logic [31:0] d;
    bus.exc_valid = 1; bus.exc_code = 5'd4; bus.exc_pc = 32'h1000;
    bus.exc_bd = 1; bus.exc_badvaddr = 32'h3;
    #1;
    vectors++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== VEC) begin
      miscompares++;
      $display("FAIL exc_flush: got %b/%h want 1/%h", bus.flush, bus.flush_pc, VEC);
    end
    step();
    idle();
    rd(5'd14, d);
    vectors++;
    if (d !== 32'h0FFC) begin miscompares++; $display("FAIL exc_epc: got %h want %h", d, 32'h0FFC); end
    rd(5'd13, d);
    vectors++;
    if (d[31] !== 1'b1 || d[6:2] !== 5'd4 || d !== exp_read(5'd13)) begin
      miscompares++; $display("FAIL exc_cause: got %h want %h", d, exp_read(5'd13));
    end
    rd(5'd8, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL exc_badv: got %h want %h", d, 32'h3); end
    vectors++;
    if (bus.status_exl !== 1'b1) begin miscompares++; $display("FAIL exc_exl: got %b want 1", bus.status_exl); end
    $display("exc code 4 pc 1000 bd 1 taken");
    // Nested exception while EXL=1
    bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h2000;
    bus.exc_bd = 0; bus.exc_badvaddr = 32'h55;
    step();
    idle();
    rd(5'd14, d);
    vectors++;
    if (d !== 32'h0FFC) begin miscompares++; $display("FAIL nest_epc: got %h want %h", d, 32'h0FFC); end
    rd(5'd13, d);
    vectors++;
    if (d[6:2] !== 5'd8 || d[31] !== 1'b1) begin
      miscompares++; $display("FAIL nest_cause: got %h want code 8 bd 1", d);
    end
    rd(5'd8, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL nest_badv: got %h want %h", d, 32'h3); end
    $display("nested exc code 8 taken");
  endtask

  task automatic test_eret();
    mtc0(5'd14, 32'h2000);
    bus.eret = 1;
    #1;
    vectors++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h2000 || bus.status_exl !== 1'b1) begin
      miscompares++;
      $display("FAIL eret_flush: got %b/%h exl %b want 1/00002000 exl 1",
               bus.flush, bus.flush_pc, bus.status_exl);
    end
    step();
    idle();
    #1;
    vectors++;
    if (bus.status_exl !== 1'b0) begin miscompares++; $display("FAIL eret_exl: got %b want 0", bus.status_exl); end
    $display("eret to 00002000");
  endtask

  task automatic test_timer();
    logic [31:0] d;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (9) step();
    rd(5'd13, d);
    vectors++;
    if (d[15] !== 1'b0) begin miscompares++; $display("FAIL timer_early: IP7 got %b want 0", d[15]); end
    step();
    rd(5'd13, d);
    vectors++;
    if (d[15] !== 1'b1 || d !== exp_read(5'd13)) begin
      miscompares++; $display("FAIL timer_ti: cause got %h want IP7 set %h", d, exp_read(5'd13));
    end
    rd(5'd9, d);
    vectors++;
    if (d !== 32'd5) begin miscompares++; $display("FAIL timer_count: got %h want %h", d, 32'd5); end
    mtc0(5'd12, 32'h0000_8001);
    #1;
    vectors++;
    if (bus.int_pending !== 1'b1) begin miscompares++; $display("FAIL timer_int: got %b want 1", bus.int_pending); end
    mtc0(5'd11, 32'd100);
    rd(5'd13, d);
    vectors++;
    if (d[15] !== 1'b0 || bus.int_pending !== 1'b0) begin
      miscompares++; $display("FAIL timer_clear: IP7 %b int %b want 0 0", d[15], bus.int_pending);
    end
    $display("timer compare 5 fired and cleared");
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus.exc_valid = 1; bus.exc_code = 5'd12; bus.exc_pc = 32'h3000; bus.exc_bd = 0;
    bus.eret = 1; bus.mtc0_we = 1; bus.cp0_addr = 5'd12; bus.mtc0_wdata = 32'h0;
    #1;
    vectors++;
    if (bus.flush !== 1'b1 || bus.flush_pc !== VEC) begin
      miscompares++; $display("FAIL prio_flush: got %b/%h want 1/%h", bus.flush, bus.flush_pc, VEC);
    end
    step();
    idle();
    rd(5'd12, d);
    vectors++;
    if (d !== 32'h0040_8003) begin miscompares++; $display("FAIL prio_status: got %h want %h", d, 32'h0040_8003); end
    rd(5'd14, d);
    vectors++;
    if (d !== 32'h3000) begin miscompares++; $display("FAIL prio_epc: got %h want %h", d, 32'h3000); end
    $display("exc+eret+mtc0 same cycle: exception won");
  endtask

  task automatic test_wrap_hwint();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_0401);
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    rd(5'd9, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_hold: got %h want ffffffff", d); end
    step();
    rd(5'd9, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %h want 0", d); end
    bus.hw_int = 6'b000001;
    #1;
    vectors++;
    if (bus.int_pending !== 1'b0) begin miscompares++; $display("FAIL hw_lag: got %b want 0", bus.int_pending); end
    step();
    bus.hw_int = 0;
    #1;
    vectors++;
    if (bus.int_pending !== 1'b1) begin miscompares++; $display("FAIL hw_int: got %b want 1", bus.int_pending); end
    step();
    vectors++;
    if (bus.int_pending !== 1'b0) begin miscompares++; $display("FAIL hw_drop: got %b want 0", bus.int_pending); end
    $display("count wrap and hw_int[0] pulse");
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    mtc0(5'd14, 32'hDEAD_BEE0);
    #2;
    resetn = 0;
    rd(5'd14, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL arst_epc: got %h want 0", d); end
    rd(5'd12, d);
    vectors++;
    if (d !== 32'h0040_0000 || bus.status_exl !== 1'b0 || bus.int_pending !== 1'b0) begin
      miscompares++; $display("FAIL arst_status: got %h exl %b int %b want 00400000 0 0",
                              d, bus.status_exl, bus.int_pending);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
    $display("async reset mid-operation");
  endtask

  task automatic test_random();
    logic [4:0]  addr_tab [7];
    logic [4:0]  code_tab [7];
    logic [4:0]  a;
    addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    code_tab = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    for (int n = 0; n < 250; n++) begin
      a = addr_tab[$urandom_range(0, 6)];
      bus.exc_valid    = ($urandom_range(0, 15) == 0);
      bus.eret         = ($urandom_range(0, 11) == 0);
      bus.mtc0_we      = ($urandom_range(0, 3) == 0);
      bus.cp0_addr     = a;
      bus.mtc0_wdata   = $urandom();
      if (a == 5'd11) bus.mtc0_wdata = m_count + $urandom_range(1, 8);
      if (a == 5'd9 && $urandom_range(0, 1) == 1) bus.mtc0_wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
      if (a == 5'd12) bus.mtc0_wdata = $urandom() & 32'hFFFF_FFFD | ($urandom_range(0, 3) == 0 ? 32'h2 : 32'h0);
      bus.exc_code     = code_tab[$urandom_range(0, 6)];
      bus.exc_pc       = $urandom() & 32'hFFFF_FFFC;
      bus.exc_bd       = $urandom_range(0, 1) == 1;
      bus.exc_badvaddr = $urandom();
      bus.hw_int       = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'h0;
      #1;
      vectors++;
      if (bus.mfc0_rdata !== exp_read(a) || bus.flush !== (bus.exc_valid | bus.eret) ||
          bus.flush_pc !== (bus.exc_valid ? VEC : m_epc) || bus.int_pending !== exp_int() ||
          bus.status_exl !== m_exl) begin
        miscompares++;
        $display("FAIL rand_%0d: r%0d=%h fl=%b pc=%h int=%b exl=%b want r=%h fl=%b pc=%h int=%b exl=%b",
                 n, a, bus.mfc0_rdata, bus.flush, bus.flush_pc, bus.int_pending, bus.status_exl,
                 exp_read(a), bus.exc_valid | bus.eret, bus.exc_valid ? VEC : m_epc, exp_int(), m_exl);
      end
      $display("rand %0d: exc=%b eret=%b we=%b r%0d rd=%h", n, bus.exc_valid, bus.eret,
               bus.mtc0_we, a, bus.mfc0_rdata);
      step();
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_exception();
    test_eret();
    test_timer();
    test_priority();
    test_wrap_hwint();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
